exponential_fp32_model: RTL and testbench
=========================================

Name: exponential_fp32_model

Overview:
- Parametrised, cycle-accurate behavioural simulation model of the FP32 exponential operator. It is the successor to the pass-through stub.
- Computes exp(x) per lane across LANES independent lanes.
- Models a fixed LATENCY pipeline with clock-enable stall, synchronous reset, and sideband/flag outputs.
- Drops into the kr260 sim tree in place of the vendor exp core, so DMA-calc benches see realistic data, timing and exceptions.

Parameters:
- LANES, 1: number of parallel FP32 lanes packed in tdata (lane 0 in bits [31:0]).
- LATENCY, 8: accepted-to-result delay in enabled cycles; legal range 1..64.
- USER_BITS, 1: width of tuser sideband, carried through unchanged.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- aresetn  in  1  synchronous active-low reset.
- aclken  in  1  global clock enable; 0 freezes the entire pipeline.
- s_axis_a_tdata  in  32*LANES  FP32 operands.
- s_axis_a_tvalid  in  1  operand valid, shared by all lanes.
- s_axis_a_tuser  in  USER_BITS  sideband, delayed alongside data.
- m_axis_result_tdata  out  32*LANES  exp results.
- m_axis_result_tvalid  out  1  result valid.
- m_axis_result_tuser  out  USER_BITS  delayed sideband.
- m_axis_result_tflags  out  3*LANES  per lane {invalid, overflow, underflow}, lane 0 in [2:0].

Behaviour:
- Reset: aresetn=0 at a rising edge clears all LATENCY stages (valid, data, user, flags = 0). Outputs read 0 from the next edge on. Reset overrides aclken. In-flight operands are discarded; no partial result emerges after reset release.
- Pipeline: no tready, so an input is accepted at every edge where aclken=1 and s_axis_a_tvalid=1. Its result appears with tvalid=1 exactly LATENCY enabled edges later.
- Stall: an edge with aclken=0 is invisible. Stages, outputs and valid all hold; inputs presented in that cycle are ignored.
- Bubbles: an edge with tvalid=0 and aclken=1 still advances the pipe. Bubble stages carry valid=0, data=0, flags=0.
- Computation: done combinationally at stage 0 and registered, then delayed LATENCY-1 stages.
- Per-lane result rules, evaluated in this order:
  - NaN input → 0x7FC00000, invalid=1.
  - +inf → 0x7F800000.
  - -inf → 0x00000000.
  - ±0 or subnormal input (DAZ) → 0x3F800000.
  - x > 88.7228391 (0x42B17218) → +inf, overflow=1.
  - x < -87.3365448 (0xC2AEAC50) → +0, underflow=1. Flush-to-zero; no subnormal outputs.
  - Otherwise: real conversion, $exp, round-to-nearest shortreal; flags 0. Tolerance ±1 ulp vs IEEE exact.
- Sign of a result is always +, except for NaN.
- Lanes are independent; one lane's flags never affect another lane.

Optional Feature:
- Macro EXPONENTIAL_FP32_MODEL_PASSTHROUGH_EN.
- Defined: each lane result equals its input bits unchanged and flags are forced 0. LATENCY, stall and reset behaviour are unchanged. This reproduces stub data for fast plumbing sims.
- Undefined: full exp computation as above.

Decomposition:
- Package exponential_fp32_pkg holds:
  - constants FP32_ONE, FP32_PINF, FP32_QNAN, FP32_ZERO, EXP_OVF_THRESH, EXP_UNF_THRESH;
  - typedef exp_flags_t (packed struct invalid/overflow/underflow);
  - function exp_fp32_eval(input [31:0]) returning result+flags.
- Sub-module exponential_fp32_delay: width-parametrised, LATENCY-deep, enable/sync-reset shift register, instantiated once for {valid, user, data, flags}.

Test Plan:
- LANES=4, LATENCY=8, aclken=1, one beat {0x00000000, 0x3F800000, 0xBF800000, 0x3F317218} → 8 edges later tvalid=1, results {0x3F800000, 0x402DF854, 0x3EBC5AB2, 0x40000000} ±1 ulp, flags 0.
- Specials beat {0x7FC00001, 0x7F800000, 0xFF800000, 0x42B20000} → {0x7FC00000, 0x7F800000, 0x00000000, 0x7F800000}; lane 0 invalid=1, lane 3 overflow=1; 0xC2B00000 on any lane → 0x00000000 with underflow=1.
- Back-to-back 20 beats with tuser incrementing 0..19, aclken toggled 1,0,0,1 pattern → outputs in order, each result after exactly 8 enabled edges, outputs stable during aclken=0, no loss or duplication.
- Fill pipe with 5 valid beats, assert aresetn=0 for one edge with aclken=0 → tvalid=0, tdata=0 next cycle; no stale results ever emerge afterwards.
- LATENCY=1, alternating valid/bubble → tvalid pattern 1,0,1,0 delayed by one edge; bubble cycles show tdata=0, flags=0.
- With EXPONENTIAL_FP32_MODEL_PASSTHROUGH_EN, input 0x40490FDB → output 0x40490FDB after LATENCY, flags 0.

Source files
------------

// File: rtl/exponential_fp32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : exponential_fp32_pkg                                         |
// | Description : Shared constants, flag type and per-lane FP32 exp evaluator  |
// |               for the exponential_fp32_model simulation core.              |
// |               The evaluator is behavioural: it uses real arithmetic and    |
// |               $exp, then rounds to FP32 (round-to-nearest-even) itself.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package exponential_fp32_pkg;

  localparam logic [31:0] FP32_ONE       = 32'h3F80_0000;
  localparam logic [31:0] FP32_PINF      = 32'h7F80_0000;
  localparam logic [31:0] FP32_QNAN      = 32'h7FC0_0000;
  localparam logic [31:0] FP32_ZERO      = 32'h0000_0000;
  // Largest x whose exp() is still computed (about 88.7228391).
  localparam logic [31:0] EXP_OVF_THRESH = 32'h42B1_7218;
  // Most negative x whose exp() is still computed (about -87.3365).
  localparam logic [31:0] EXP_UNF_THRESH = 32'hC2AE_AC50;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
  } exp_flags_t;

  typedef struct packed {
    logic [31:0] result;
    exp_flags_t  flags;
  } exp_result_t;

  function automatic exp_result_t exp_fp32_eval(input logic [31:0] x);
    exp_result_t r;
    logic [63:0] xd;
    logic [62:0] yd;
    real         yr;
    int          e;
    logic [23:0] mant;
    logic        rnd_up;

    r.result = FP32_ZERO;
    r.flags  = '0;
    xd       = '0;
    yd       = '0;
    yr       = 0.0;
    e        = 0;
    mant     = '0;
    rnd_up   = 1'b0;

    if (x[30:23] == 8'hFF && x[22:0] != 23'd0) begin
      r.result        = FP32_QNAN;
      r.flags.invalid = 1'b1;
    end else if (x[30:23] == 8'hFF) begin
      r.result = x[31] ? FP32_ZERO : FP32_PINF;
    end else if (x[30:23] == 8'h00) begin
      // Zero and subnormal inputs are treated as zero (DAZ).
      r.result = FP32_ONE;
    end else if (!x[31] && (x[30:0] > EXP_OVF_THRESH[30:0])) begin
      r.result         = FP32_PINF;
      r.flags.overflow = 1'b1;
    end else if (x[31] && (x[30:0] > EXP_UNF_THRESH[30:0])) begin
      r.result          = FP32_ZERO;
      r.flags.underflow = 1'b1;
    end else begin
      // Widen the normal FP32 operand to an exact double (rebias 127 -> 1023).
      xd = {x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'd0};
      yr = $exp($bitstoreal(xd));
      // exp() is never negative, so the double's sign bit is dropped.
      yd = 63'($realtobits(yr));
      e  = int'(yd[62:52]) - 896;
      if (e <= 0) begin
        // Below the smallest normal: flush to zero, never a subnormal.
        r.result          = FP32_ZERO;
        r.flags.underflow = 1'b1;
      end else begin
        // Round-to-nearest-even on the 29 discarded mantissa bits.
        rnd_up = yd[28] && ((|yd[27:0]) || yd[29]);
        mant   = {1'b0, yd[51:29]} + 24'(rnd_up);
        if (mant[23]) begin
          e = e + 1;  // fraction wrapped to zero, bump the exponent
        end
        if (e >= 255) begin
          r.result         = FP32_PINF;
          r.flags.overflow = 1'b1;
        end else begin
          r.result = {1'b0, e[7:0], mant[22:0]};
        end
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exponential_fp32_delay.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : exponential_fp32_delay                                       |
// | Description : DEPTH-deep shift register with clock enable and synchronous  |
// |               active-low clear. Carries one packed word per stage.         |
// | Ports       : clk     - clock                                              |
// |               rst_n   - synchronous active-low clear of every stage        |
// |               i_en    - advance enable; 0 holds all stages                 |
// |               i_data  - word loaded into stage 0                           |
// |               o_data  - last stage                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module exponential_fp32_delay
  import exponential_fp32_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else if (i_en) begin
      r_stage[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_data = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/exponential_fp32_model.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : exponential_fp32_model                                       |
// | Description : Cycle-accurate behavioural model of an FP32 exp() core with  |
// |               LANES independent lanes and a fixed LATENCY pipeline.        |
// |               Build option EXPONENTIAL_FP32_MODEL_PASSTHROUGH_EN: each     |
// |               lane returns its operand unchanged with flags 0; timing,     |
// |               stall and reset behaviour are identical.                     |
// | Ports       : aclk/aresetn/aclken      - clock, sync active-low reset,     |
// |                                          global clock enable               |
// |               s_axis_a_tdata/tvalid/tuser - operands (lane 0 = [31:0])     |
// |               m_axis_result_tdata/tvalid/tuser - results                   |
// |               m_axis_result_tflags     - {invalid,overflow,underflow}/lane |
// | Parameters  : LANES, LATENCY (1..64), USER_BITS                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module exponential_fp32_model
  import exponential_fp32_pkg::*;
#(
  parameter int LANES     = 1,
  parameter int LATENCY   = 8,
  parameter int USER_BITS = 1
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   aclken,
  input  logic [32*LANES-1:0]    s_axis_a_tdata,
  input  logic                   s_axis_a_tvalid,
  input  logic [USER_BITS-1:0]   s_axis_a_tuser,
  output logic [32*LANES-1:0]    m_axis_result_tdata,
  output logic                   m_axis_result_tvalid,
  output logic [USER_BITS-1:0]   m_axis_result_tuser,
  output logic [3*LANES-1:0]     m_axis_result_tflags
);

  localparam int STAGE_W = 1 + USER_BITS + 32 * LANES + 3 * LANES;

  logic [32*LANES-1:0] w_data;
  logic [3*LANES-1:0]  w_flags;
  logic [STAGE_W-1:0]  w_stage_in;
  logic [STAGE_W-1:0]  w_stage_out;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
`ifdef EXPONENTIAL_FP32_MODEL_PASSTHROUGH_EN
    assign w_data[32*l +: 32] = s_axis_a_tdata[32*l +: 32];
    assign w_flags[3*l +: 3]  = 3'b000;
`else
    exp_result_t w_eval;
    assign w_eval             = exp_fp32_eval(s_axis_a_tdata[32*l +: 32]);
    assign w_data[32*l +: 32] = w_eval.result;
    assign w_flags[3*l +: 3]  = w_eval.flags;
`endif
  end

  // Bubbles travel with zero data and flags so idle output beats read clean.
  assign w_stage_in = {s_axis_a_tvalid,
                       s_axis_a_tuser,
                       s_axis_a_tvalid ? w_data  : '0,
                       s_axis_a_tvalid ? w_flags : '0};

  exponential_fp32_delay #(
    .WIDTH (STAGE_W),
    .DEPTH (LATENCY)
  ) u_delay (
    .clk    (aclk),
    .rst_n  (aresetn),
    .i_en   (aclken),
    .i_data (w_stage_in),
    .o_data (w_stage_out)
  );

  assign {m_axis_result_tvalid,
          m_axis_result_tuser,
          m_axis_result_tdata,
          m_axis_result_tflags} = w_stage_out;

endmodule
`default_nettype wire

// File: tb/tb_exponential_fp32_model.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_exponential_fp32_model                                    |
// | Description : Scoreboard bench for exponential_fp32_model (4 lanes,        |
// |               latency 8): directed specials/thresholds, stall pattern,     |
// |               reset flush and randomized traffic against a real-valued     |
// |               exp() reference.                                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_exponential_fp32_model;

  localparam int LANES = 4;
  localparam int LAT   = 8;
  localparam int UB    = 8;

  logic               clk = 1'b0;
  logic               aresetn = 1'b0;
  logic               aclken = 1'b1;
  logic [32*LANES-1:0] s_tdata = '0;
  logic               s_tvalid = 1'b0;
  logic [UB-1:0]      s_tuser = '0;
  logic [32*LANES-1:0] m_tdata;
  logic               m_tvalid;
  logic [UB-1:0]      m_tuser;
  logic [3*LANES-1:0] m_tflags;

  exponential_fp32_model #(.LANES(LANES), .LATENCY(LAT), .USER_BITS(UB)) dut (
    .aclk                 (clk),
    .aresetn              (aresetn),
    .aclken               (aclken),
    .s_axis_a_tdata       (s_tdata),
    .s_axis_a_tvalid      (s_tvalid),
    .s_axis_a_tuser       (s_tuser),
    .m_axis_result_tdata  (m_tdata),
    .m_axis_result_tvalid (m_tvalid),
    .m_axis_result_tuser  (m_tuser),
    .m_axis_result_tflags (m_tflags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [32*LANES-1:0] d;
    logic [UB-1:0]       u;
    int unsigned         cnt;
  } item_t;

  item_t       exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned en_cnt = 0;   // enabled, non-reset edges so far
  bit          last_en = 1'b0;
  bit          last_rst = 1'b1;
  bit          started = 1'b0;
  logic [32*LANES+3*LANES+UB:0] snap;

  // ---------------- reference model ----------------
  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp_to_real(input logic [31:0] b);
    real m;
    m = 1.0 + real'(int'(b[22:0])) / 8388608.0;
    m = m * pow2(int'(b[30:23]) - 127);
    return b[31] ? -m : m;
  endfunction

  task automatic model_lane(input logic [31:0] x, output logic [31:0] res,
                            output logic [2:0] fl, output bit approx, output real refv);
    real xv;
    approx = 1'b0; refv = 0.0; fl = 3'b000; res = 32'h0;
`ifdef EXPONENTIAL_FP32_MODEL_PASSTHROUGH_EN
    res = x;
`else
    if (x[30:23] == 8'hFF && x[22:0] != 0) begin res = 32'h7FC00000; fl = 3'b100; end
    else if (x[30:23] == 8'hFF) res = x[31] ? 32'h0 : 32'h7F800000;
    else if (x[30:23] == 8'h00) res = 32'h3F800000;
    else begin
      xv = fp_to_real(x);
      if (xv > fp_to_real(32'h42B17218))      begin res = 32'h7F800000; fl = 3'b010; end
      else if (xv < fp_to_real(32'hC2AEAC50)) begin res = 32'h0;        fl = 3'b001; end
      else begin
        refv = $exp(xv);
        if (refv > (2.0 - pow2(-23)) * pow2(127)) begin res = 32'h7F800000; fl = 3'b010; end
        else if (refv < pow2(-126))               begin res = 32'h0;        fl = 3'b001; end
        else approx = 1'b1;
      end
    end
`endif
  endtask

  // ---------------- stimulus ----------------
  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 15))
      0: v[30:23] = 8'hFF;
      1: begin v[30:23] = 8'hFF; v[22:0] = '0; end
      2: v[30:23] = 8'h00;
      default: v[30:23] = 8'($urandom_range(100, 133));
    endcase
    if (v[30:23] == 8'hFF && $urandom_range(0, 1) == 0) v[0] = 1'b1;
    return v;
  endfunction

  task automatic drive(input bit en, input bit rstn, input bit v,
                       input logic [32*LANES-1:0] d, input logic [UB-1:0] u);
    item_t it;
    @(negedge clk); #1;
    aclken = en; aresetn = rstn; s_tvalid = v; s_tdata = d; s_tuser = u;
    @(posedge clk); #1;
    last_en = en; last_rst = !rstn; started = 1'b1;
    if (!rstn) exp_q.delete();
    else if (en) begin
      if (v) begin it.d = d; it.u = u; it.cnt = en_cnt; exp_q.push_back(it); end
      en_cnt++;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    item_t       it;
    logic [31:0] er, ar;
    logic [2:0]  ef, af;
    bit          ap, ok;
    real         rv, diff;
    if (started) begin
      if (last_rst) begin
        n_cmp++;
        if (m_tvalid !== 1'b0 || m_tdata !== '0 || m_tflags !== '0 || m_tuser !== '0) begin
          n_err++;
          $display("FAIL reset_clear valid=%b data=%h flags=%h user=%h required all 0",
                   m_tvalid, m_tdata, m_tflags, m_tuser);
        end
      end else if (!last_en) begin
        n_cmp++;
        if ({m_tvalid, m_tuser, m_tdata, m_tflags} !== snap) begin
          n_err++;
          $display("FAIL stall_hold outputs=%h required=%h", {m_tvalid, m_tuser, m_tdata, m_tflags}, snap);
        end
      end else if (m_tvalid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_valid data=%h required no result", m_tdata);
        end else begin
          it = exp_q.pop_front();
          if (en_cnt - it.cnt != LAT || m_tuser !== it.u) begin
            n_err++;
            $display("FAIL latency_user latency=%0d user=%h required latency=%0d user=%h",
                     en_cnt - it.cnt, m_tuser, LAT, it.u);
          end
          for (int l = 0; l < LANES; l++) begin
            model_lane(it.d[32*l +: 32], er, ef, ap, rv);
            ar = m_tdata[32*l +: 32];
            af = m_tflags[3*l +: 3];
            n_cmp++;
            if (ap) begin
              diff = fp_to_real(ar) - rv;
              if (diff < 0.0) diff = -diff;
              ok = (af == 3'b000) && !ar[31] && ar[30:23] != 8'h00 && ar[30:23] != 8'hFF &&
                   diff <= pow2(int'(ar[30:23]) - 150);
            end else begin
              ok = (ar === er) && (af === ef);
            end
            if (!ok) begin
              n_err++;
              $display("FAIL lane%0d in=%h result=%h flags=%b required=%h flags=%b approx=%0d ref=%g",
                       l, it.d[32*l +: 32], ar, af, er, ef, ap, rv);
            end
          end
        end
      end else begin
        n_cmp++;
        if (m_tvalid !== 1'b0 || m_tdata !== '0 || m_tflags !== '0) begin
          n_err++;
          $display("FAIL bubble valid=%b data=%h flags=%h required 0/0/0", m_tvalid, m_tdata, m_tflags);
        end
      end
    end
    snap = {m_tvalid, m_tuser, m_tdata, m_tflags};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached, vectors=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------- sequence ----------------
  initial begin
    int          acc;
    int          k;
    logic [31:0] lanes [4];
    logic [32*LANES-1:0] d;
    logic [UB-1:0]       u;

    repeat (3) drive(1, 0, 0, '0, '0);

    // Directed beats (lane 0 in the low word).
    drive(1, 1, 1, {32'h3F317218, 32'hBF800000, 32'h3F800000, 32'h00000000}, 8'hA0);
    drive(1, 1, 1, {32'h42B20000, 32'hFF800000, 32'h7F800000, 32'h7FC00001}, 8'hA1);
    drive(1, 1, 1, {32'h80000000, 32'h00400000, 32'hC2B00000, 32'hC2B00000}, 8'hA2);
    drive(1, 1, 1, {32'hC2AEAC4F, 32'hC2AEAC51, 32'h42B17217, 32'h42B17219}, 8'hA3);
    drive(1, 1, 1, {32'h40490FDB, 32'hC0490FDB, 32'h3C000000, 32'hBC000000}, 8'hA4);
    repeat (LAT + 2) drive(1, 1, 0, '0, '0);

    // Back-to-back with aclken pattern 1,0,0,1; tuser advances only on accept.
    acc = 0; k = 0;
    while (acc < 20) begin
      for (int l = 0; l < 4; l++) lanes[l] = rand_op();
      d = {lanes[3], lanes[2], lanes[1], lanes[0]};
      if (k % 4 == 0 || k % 4 == 3) begin drive(1, 1, 1, d, 8'(acc)); acc++; end
      else drive(0, 1, 1, d, 8'hEE);
      k++;
    end
    repeat (LAT + 2) drive(1, 1, 0, '0, '0);

    // Fill with 5 beats, then reset during a stalled edge: nothing may emerge.
    for (int i = 0; i < 5; i++) drive(1, 1, 1, {4{rand_op()}}, 8'(i));
    drive(0, 0, 1, {4{32'h3F800000}}, 8'h55);
    repeat (LAT + 3) drive(1, 1, 0, '0, '0);

    // Randomized traffic with stalls, bubbles and rare resets.
    for (int i = 0; i < 400; i++) begin
      for (int l = 0; l < 4; l++) lanes[l] = rand_op();
      d = {lanes[3], lanes[2], lanes[1], lanes[0]};
      u = 8'($urandom);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 99) != 0,
            $urandom_range(0, 4) < 3, d, u);
    end
    repeat (LAT + 2) drive(1, 1, 0, '0, '0);

    @(negedge clk); #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_empty outstanding=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
